// File: rtl/serial_paralelo_if.sv
// Receive-side serial link bundle: one serial bit in, one deserialized
// 10-bit code group out with its qualifiers.
interface serial_paralelo_if #(
    parameter int CANT_BITS = 10
);
    logic                 entrada;
    logic [CANT_BITS-1:0] salidas;
    logic                 valido;
    logic                 es_coma;
    logic                 sincronizado;

    // Link side: drives the serial line and watches the recovered words.
    modport master (
        output entrada,
        input  salidas,
        input  valido,
        input  es_coma,
        input  sincronizado
    );

    // Deserializer side.
    modport slave (
        input  entrada,
        output salidas,
        output valido,
        output es_coma,
        output sincronizado
    );
endinterface

// File: rtl/serial_paralelo.sv
// Deserializer: shifts the serial line LSB-first into a 10-bit window,
// hunts for a K28.5 comma to find word alignment, then emits one code
// group every CANT_BITS clocks. Repeated commas seen off the locked phase
// mean the link slipped, so after PERDIDA_MAX of them alignment is dropped
// and the hunt restarts.
module serial_paralelo #(
    parameter int                   CANT_BITS   = 10,
    parameter logic [CANT_BITS-1:0] COMA_POS    = 10'h17C,
    parameter logic [CANT_BITS-1:0] COMA_NEG    = 10'h283,
    parameter int                   PERDIDA_MAX = 4
) (
    input  logic               clk,
    input  logic               reset_L,
    serial_paralelo_if.slave   bus
);
    localparam int MISS_W = $clog2(PERDIDA_MAX + 1);
    localparam logic [3:0]        CNT_LAST  = 4'(CANT_BITS - 1);
    localparam logic [MISS_W-1:0] MISS_LIM  = MISS_W'(PERDIDA_MAX);
    localparam logic [MISS_W-1:0] MISS_SAT  = {MISS_W{1'b1}};

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } estado_t;

    estado_t              estado;
    logic [CANT_BITS-1:0] ventana;
    logic [CANT_BITS-1:0] ventana_next;
    logic [3:0]           cont_bits;
    logic [MISS_W-1:0]    cont_perdidas;
    logic [MISS_W-1:0]    perdidas_next;
    logic                 coma_det;
    logic                 frontera;

    logic [CANT_BITS-1:0] salidas_reg;
    logic                 valido_reg;
    logic                 es_coma_reg;
    logic                 sincronizado_reg;

    // New bit enters at the top so that, after a full word, bit0 holds the
    // first bit received on the line.
    genvar gi;
    generate
        for (gi = 0; gi < CANT_BITS - 1; gi++) begin : g_shift
            assign ventana_next[gi] = ventana[gi+1];
        end
    endgenerate
    assign ventana_next[CANT_BITS-1] = bus.entrada;

    // Comparing against the next window lets a comma be acted on at the
    // very edge its last bit arrives.
    assign coma_det = (ventana_next == COMA_POS) || (ventana_next == COMA_NEG);
    assign frontera = (cont_bits == CNT_LAST);

    // Saturating increment of the misaligned-comma count.
    always_comb begin
        perdidas_next = cont_perdidas;
        if (cont_perdidas != MISS_SAT) begin
            perdidas_next = cont_perdidas + MISS_W'(1);
        end
    end

    // Alignment FSM with registered outputs; the shift register runs in
    // every state.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            estado           <= HUNT;
            ventana          <= '0;
            cont_bits        <= '0;
            cont_perdidas    <= '0;
            salidas_reg      <= '0;
            valido_reg       <= 1'b0;
            es_coma_reg      <= 1'b0;
            sincronizado_reg <= 1'b0;
        end else begin
            ventana    <= ventana_next;
            valido_reg <= 1'b0;
            case (estado)
                HUNT: begin
                    if (coma_det) begin
                        estado           <= SYNC;
                        sincronizado_reg <= 1'b1;
                        salidas_reg      <= ventana_next;
                        valido_reg       <= 1'b1;
                        es_coma_reg      <= 1'b1;
                        cont_bits        <= '0;
                        cont_perdidas    <= '0;
                    end
                end
                SYNC: begin
                    cont_bits <= frontera ? 4'd0 : cont_bits + 4'd1;
                    if (frontera) begin
                        salidas_reg <= ventana_next;
                        valido_reg  <= 1'b1;
                        es_coma_reg <= coma_det;
                        if (coma_det) begin
                            cont_perdidas <= '0;
                        end
                    end else if (coma_det) begin
                        // A comma off our phase: the link may have slipped.
                        cont_perdidas <= perdidas_next;
                        if (perdidas_next >= MISS_LIM) begin
                            estado           <= HUNT;
                            sincronizado_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    estado           <= HUNT;
                    sincronizado_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.salidas      = salidas_reg;
    assign bus.valido       = valido_reg;
    assign bus.es_coma      = es_coma_reg;
    assign bus.sincronizado = sincronizado_reg;
endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench for the comma-aligned deserializer.
module tb_serial_paralelo;
    logic clk;
    logic reset_L;
    int   checks;
    int   errors;

    serial_paralelo_if #(.CANT_BITS(10)) bus ();

    serial_paralelo dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Neutral-disparity 6b and 4b sub-blocks in line order (MSB sent first).
    logic [5:0] six_tab [12] = '{6'b101010, 6'b010101, 6'b101001, 6'b011001,
                                  6'b100101, 6'b001101, 6'b110010, 6'b100110,
                                  6'b010110, 6'b101100, 6'b011100, 6'b110001};
    logic [3:0] four_tab [4] = '{4'b1001, 4'b0101, 4'b1010, 4'b0110};

    function automatic logic [9:0] rev10(input logic [9:0] l);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = l[9-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.entrada = b;
        @(posedge clk);
        #1;
    endtask

    // Sends w LSB first; exp_pos is the bit index whose edge should raise
    // valido (-1 for none). Checks data/comma at that pulse and sync at end.
    task automatic send_word(input logic [9:0] w, input int exp_pos, input logic [9:0] exp_w,
                             input logic exp_c, input logic exp_s, input string tag);
        int         pos;
        logic [9:0] got_w;
        logic       got_c;
        pos   = -1;
        got_w = '0;
        got_c = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_bit(w[i]);
            if (bus.valido === 1'b1) begin
                pos   = (pos == -1) ? i : -2;
                got_w = bus.salidas;
                got_c = bus.es_coma;
            end
        end
        chk({tag, "_vpos"}, pos, exp_pos);
        if (exp_pos >= 0) begin
            chk({tag, "_data"}, {22'd0, got_w}, {22'd0, exp_w});
            chk({tag, "_coma"}, {31'd0, got_c}, {31'd0, exp_c});
        end
        chk({tag, "_sync"}, {31'd0, bus.sincronizado}, {31'd0, exp_s});
    endtask

    task automatic filler9();
        for (int i = 0; i < 9; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    endtask

    initial begin
        logic [9:0] w;
        logic [9:0] coma;
        checks = 0;
        errors = 0;
        reset_L = 1'b0;
        bus.entrada = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_salidas", {22'd0, bus.salidas}, 32'd0);
        chk("rst_valido", {31'd0, bus.valido}, 32'd0);
        chk("rst_coma", {31'd0, bus.es_coma}, 32'd0);
        chk("rst_sync", {31'd0, bus.sincronizado}, 32'd0);
        reset_L = 1'b1;

        // Lock: junk 1,0,1 then K28.5 RD-.
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("hunt_sync", {31'd0, bus.sincronizado}, 32'd0);
        send_word(10'h17C, 9, 10'h17C, 1'b1, 1'b1, "lock");

        // Aligned data words.
        send_word(10'h2AA, 9, 10'h2AA, 1'b0, 1'b1, "w2AA");
        send_word(10'h155, 9, 10'h155, 1'b0, 1'b1, "w155");
        send_word(10'h283, 9, 10'h283, 1'b1, 1'b1, "w283");

        // Asynchronous reset mid-word, then relock.
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        #2;
        reset_L = 1'b0;
        #1;
        chk("arst_salidas", {22'd0, bus.salidas}, 32'd0);
        chk("arst_coma", {31'd0, bus.es_coma}, 32'd0);
        chk("arst_sync", {31'd0, bus.sincronizado}, 32'd0);
        @(posedge clk);
        #1;
        chk("arst_valido", {31'd0, bus.valido}, 32'd0);
        reset_L = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("rehunt_sync", {31'd0, bus.sincronizado}, 32'd0);
        send_word(10'h17C, 9, 10'h17C, 1'b1, 1'b1, "relock1");

        // One slipped bit, then four commas off phase: sync lost on the 4th.
        send_bit(1'b0);
        send_word(10'h17C, 8, 10'h2F8, 1'b0, 1'b1, "slip1");
        send_word(10'h17C, 8, 10'h2F8, 1'b0, 1'b1, "slip2");
        send_word(10'h17C, 8, 10'h2F8, 1'b0, 1'b1, "slip3");
        send_word(10'h17C, 8, 10'h2F8, 1'b0, 1'b0, "slip4");
        send_word(10'h283, 9, 10'h283, 1'b1, 1'b1, "relock2");
        send_word(10'h2AA, 9, 10'h2AA, 1'b0, 1'b1, "newphase");

        // Three slipped commas, one aligned comma clears the count, three more.
        send_bit(1'b0);
        send_word(10'h17C, 8, 10'h2F8, 1'b0, 1'b1, "missa1");
        send_word(10'h17C, 8, 10'h2F8, 1'b0, 1'b1, "missa2");
        send_word(10'h17C, 8, 10'h2F8, 1'b0, 1'b1, "missa3");
        filler9();
        send_word(10'h17C, 9, 10'h17C, 1'b1, 1'b1, "aligned");
        send_bit(1'b0);
        send_word(10'h17C, 8, 10'h2F8, 1'b0, 1'b1, "missb1");
        send_word(10'h17C, 8, 10'h2F8, 1'b0, 1'b1, "missb2");
        send_word(10'h17C, 8, 10'h2F8, 1'b0, 1'b1, "missb3");

        // Back to the locked phase, then a long stream with periodic commas.
        filler9();
        coma = 10'h17C;
        for (int k = 0; k < 200; k++) begin
            if (k % 8 == 0) begin
                send_word(coma, 9, coma, 1'b1, 1'b1, $sformatf("s%0d", k));
                coma = (coma == 10'h17C) ? 10'h283 : 10'h17C;
            end else begin
                w = rev10({six_tab[$urandom_range(0, 11)], four_tab[$urandom_range(0, 3)]});
                send_word(w, 9, w, 1'b0, 1'b1, $sformatf("s%0d", k));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
